// File: rtl/kugelblitz_rx_offload.sv
// CMAC RX offload: masks bytes not enabled by tkeep, flags runt/oversize frames,
// truncates oversize frames and keeps per-port receive status counters.
`timescale 1ns/1ps
module kugelblitz_rx_offload #(
   parameter int unsigned DATA_WIDTH    = 512,
   parameter int unsigned KEEP_WIDTH    = DATA_WIDTH/8,
   parameter int unsigned USER_WIDTH    = 1,
   parameter int unsigned MIN_FRAME_LEN = 64,
   parameter int unsigned MAX_FRAME_LEN = 1518,
   parameter int unsigned LEN_WIDTH     = 16
) (
   input  logic                  qsfp_rx_clk,
   input  logic                  qsfp_rx_rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic [31:0]           stat_frames,
   output logic [31:0]           stat_runt,
   output logic [31:0]           stat_oversize,
   output logic [31:0]           stat_rx_err
);

   localparam int unsigned CNT_W = $clog2(KEEP_WIDTH + 1);
   localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_FRAME_LEN);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);

   if (DATA_WIDTH != 512 || KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_width
      $error("kugelblitz_rx_offload supports only DATA_WIDTH=512 with KEEP_WIDTH=64");
   end
   if (MAX_FRAME_LEN >= 65535) begin : g_bad_max
      $error("kugelblitz_rx_offload requires MAX_FRAME_LEN < 65535");
   end

   typedef enum logic {ST_PASS = 1'b0, ST_DROP = 1'b1} state_e;

   state_e                state_q,    state_d;
   logic [LEN_WIDTH-1:0]  len_q,      len_d;
   logic [DATA_WIDTH-1:0] tdata_q,    tdata_d;
   logic [KEEP_WIDTH-1:0] tkeep_q,    tkeep_d;
   logic                  tvalid_q,   tvalid_d;
   logic                  tlast_q,    tlast_d;
   logic [USER_WIDTH-1:0] tuser_q,    tuser_d;
   logic [31:0]           frames_q,   frames_d;
   logic [31:0]           runt_q,     runt_d;
   logic [31:0]           oversize_q, oversize_d;
   logic [31:0]           rx_err_q,   rx_err_d;

   logic [CNT_W-1:0]      beat_bytes;
   logic [DATA_WIDTH-1:0] masked;
   logic [LEN_WIDTH:0]    len_sum;
   logic [LEN_WIDTH-1:0]  len_next;
   logic                  is_runt;
   logic                  is_over;
   logic                  accept;

   // Byte masking, beat byte count and saturating running frame length.
   always_comb begin
      beat_bytes = '0;
      masked     = '0;
      for (int k = 0; k < KEEP_WIDTH; k++) begin
         beat_bytes          = beat_bytes + CNT_W'(s_axis_tkeep[k]);
         masked[k*8 +: 8]    = s_axis_tkeep[k] ? s_axis_tdata[k*8 +: 8] : 8'h00;
      end
      len_sum  = {1'b0, len_q} + (LEN_WIDTH+1)'(beat_bytes);
      len_next = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
      is_runt  = (len_next < MIN_LEN);
      is_over  = (len_next > MAX_LEN);
   end

   // While dropping an oversize tail the input never waits on the output stage.
   assign s_axis_tready = qsfp_rx_rst_n &&
                          ((state_q == ST_DROP) || !tvalid_q || m_axis_tready);
   assign accept        = s_axis_tvalid && s_axis_tready;

   // Next-state, output-stage and counter update.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      tdata_d    = tdata_q;
      tkeep_d    = tkeep_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;
      tuser_d    = tuser_q;
      frames_d   = frames_q;
      runt_d     = runt_q;
      oversize_d = oversize_q;
      rx_err_d   = rx_err_q;

      if (tvalid_q && m_axis_tready) begin
         tvalid_d = 1'b0;
      end

      if (accept) begin
         case (state_q)
            ST_PASS: begin
               tdata_d  = masked;
               tkeep_d  = s_axis_tkeep;
               tuser_d  = s_axis_tuser;
               tlast_d  = s_axis_tlast;
               tvalid_d = 1'b1;
               if (s_axis_tlast) begin
                  tuser_d[0] = s_axis_tuser[0] | is_runt | is_over;
                  len_d      = '0;
                  frames_d   = frames_q + 32'd1;
                  if (is_runt)         runt_d     = runt_q + 32'd1;
                  if (is_over)         oversize_d = oversize_q + 32'd1;
                  if (s_axis_tuser[0]) rx_err_d   = rx_err_q + 32'd1;
               end else if (is_over) begin
                  tlast_d    = 1'b1;
                  tuser_d[0] = 1'b1;
                  len_d      = '0;
                  frames_d   = frames_q + 32'd1;
                  oversize_d = oversize_q + 32'd1;
                  state_d    = ST_DROP;
               end else begin
                  len_d = len_next;
               end
            end
            ST_DROP: begin
               if (s_axis_tlast) begin
                  if (s_axis_tuser[0]) rx_err_d = rx_err_q + 32'd1;
                  len_d   = '0;
                  state_d = ST_PASS;
               end
            end
            default: state_d = ST_PASS;
         endcase
      end
   end

   always_ff @(posedge qsfp_rx_clk or negedge qsfp_rx_rst_n) begin
      if (!qsfp_rx_rst_n) begin
         state_q    <= ST_PASS;
         len_q      <= '0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tuser_q    <= '0;
         frames_q   <= '0;
         runt_q     <= '0;
         oversize_q <= '0;
         rx_err_q   <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         tdata_q    <= tdata_d;
         tkeep_q    <= tkeep_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tuser_q    <= tuser_d;
         frames_q   <= frames_d;
         runt_q     <= runt_d;
         oversize_q <= oversize_d;
         rx_err_q   <= rx_err_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign stat_frames   = frames_q;
   assign stat_runt     = runt_q;
   assign stat_oversize = oversize_q;
   assign stat_rx_err   = rx_err_q;

endmodule

// File: tb/tb_kugelblitz_rx_offload.sv
// Bench for kugelblitz_rx_offload: frame-level reference model and scoreboard,
// directed frames plus randomized traffic with random valid/ready.
`timescale 1ns/1ps
module tb_kugelblitz_rx_offload;

   localparam int unsigned DW   = 512;
   localparam int unsigned KW   = 64;
   localparam int unsigned UW   = 1;
   localparam int          MINL = 64;
   localparam int          MAXL = 1518;
   localparam int unsigned CW   = 640;
   typedef logic [CW-1:0] cv_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
   } beat_t;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [UW-1:0] s_axis_tuser;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [UW-1:0] m_axis_tuser;
   logic [31:0]   stat_frames, stat_runt, stat_oversize, stat_rx_err;

   kugelblitz_rx_offload dut (
      .qsfp_rx_clk   (clk),
      .qsfp_rx_rst_n (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .stat_frames   (stat_frames),
      .stat_runt     (stat_runt),
      .stat_oversize (stat_oversize),
      .stat_rx_err   (stat_rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input cv_t got, input cv_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard and model state
   beat_t       in_q[$];
   beat_t       fr_q[$];
   cv_t         exp_q[$];
   logic [31:0] e_frames, e_runt, e_over, e_err;

   bit  presenting, vld_always, chk_stall, hold_pend;
   cv_t hold_val;
   int  rdy_mode, pat_idx, cyc, acc_cnt, out_cnt;
   int  first_out_cyc, last_out_cyc, first_acc_cyc;
   bit  pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   function automatic logic [DW-1:0] rand512();
      logic [DW-1:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d, input logic [KW-1:0] k);
      logic [DW-1:0] r;
      for (int i = 0; i < KW; i++) r[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
      return r;
   endfunction

   function automatic cv_t pack(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                input logic l, input logic u, input logic v);
      return cv_t'({v, d, k, l, u});
   endfunction

   function automatic cv_t out_now();
      return pack(m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser[0], m_axis_tvalid);
   endfunction

   task automatic build_frame(input int n, input logic [KW-1:0] last_keep,
                              input bit ff, input bit err_last);
      beat_t b;
      fr_q.delete();
      for (int i = 0; i < n; i++) begin
         b.data = ff ? '1 : rand512();
         b.keep = (i == n - 1) ? last_keep : '1;
         b.last = (i == n - 1);
         b.user = (i == n - 1) ? err_last : 1'b0;
         fr_q.push_back(b);
      end
   endtask

   // Frame-level model: cumulative byte count decides runt/oversize/truncation.
   task automatic model_frame();
      int cum;
      bit dropping;
      cum      = 0;
      dropping = 0;
      foreach (fr_q[i]) begin
         in_q.push_back(fr_q[i]);
         if (dropping) begin
            if (fr_q[i].last && fr_q[i].user) e_err++;
         end else begin
            cum += $countones(fr_q[i].keep);
            if (fr_q[i].last) begin
               exp_q.push_back(pack(mask_bytes(fr_q[i].data, fr_q[i].keep), fr_q[i].keep, 1'b1,
                                    fr_q[i].user | (cum < MINL) | (cum > MAXL), 1'b1));
               e_frames++;
               if (cum < MINL)   e_runt++;
               if (cum > MAXL)   e_over++;
               if (fr_q[i].user) e_err++;
            end else if (cum > MAXL) begin
               exp_q.push_back(pack(mask_bytes(fr_q[i].data, fr_q[i].keep), fr_q[i].keep,
                                    1'b1, 1'b1, 1'b1));
               e_frames++;
               e_over++;
               dropping = 1;
            end else begin
               exp_q.push_back(pack(mask_bytes(fr_q[i].data, fr_q[i].keep), fr_q[i].keep,
                                    1'b0, fr_q[i].user, 1'b1));
            end
         end
      end
   endtask

   task automatic clr_trk();
      acc_cnt       = 0;
      out_cnt       = 0;
      first_out_cyc = -1;
      last_out_cyc  = -1;
      first_acc_cyc = -1;
      pat_idx       = 0;
   endtask

   // One clock: drive at posedge+1, observe handshakes at negedge.
   task automatic step();
      cv_t cur;
      if (!presenting && in_q.size() > 0 && (vld_always || $urandom_range(3) != 0))
         presenting = 1;
      if (presenting) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = in_q[0].data;
         s_axis_tkeep  = in_q[0].keep;
         s_axis_tlast  = in_q[0].last;
         s_axis_tuser  = in_q[0].user;
      end else begin
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = rand512();
         s_axis_tkeep  = {$urandom, $urandom};
         s_axis_tlast  = 1'($urandom_range(1));
         s_axis_tuser  = 1'($urandom_range(1));
      end
      case (rdy_mode)
         0:       m_axis_tready = ($urandom_range(3) != 0);
         1:       m_axis_tready = 1'b1;
         default: begin
            m_axis_tready = (pat_idx < 7) ? pat[pat_idx] : 1'b1;
            pat_idx++;
         end
      endcase
      @(negedge clk);
      cur = out_now();
      if (chk_stall && m_axis_tvalid && !m_axis_tready)
         chk("stall_s_tready", cv_t'(s_axis_tready), cv_t'(0));
      if (hold_pend) chk("hold_stable", cur, hold_val);
      hold_pend = m_axis_tvalid && !m_axis_tready;
      hold_val  = cur;
      if (s_axis_tvalid && s_axis_tready) begin
         void'(in_q.pop_front());
         presenting = 0;
         acc_cnt++;
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) chk("extra_beat", cur, cv_t'(0));
         else                   chk("out_beat", cur, exp_q.pop_front());
         out_cnt++;
         if (first_out_cyc < 0) first_out_cyc = cyc;
         last_out_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0 || m_axis_tvalid) && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) chk("drain_timeout", cv_t'(exp_q.size() + in_q.size()), cv_t'(0));
   endtask

   task automatic chk_cnt(input string t);
      chk({t, "_frames"},   cv_t'(stat_frames),   cv_t'(e_frames));
      chk({t, "_runt"},     cv_t'(stat_runt),     cv_t'(e_runt));
      chk({t, "_oversize"}, cv_t'(stat_oversize), cv_t'(e_over));
      chk({t, "_rx_err"},   cv_t'(stat_rx_err),   cv_t'(e_err));
   endtask

   task automatic model_reset();
      in_q.delete();
      exp_q.delete();
      e_frames   = '0;
      e_runt     = '0;
      e_over     = '0;
      e_err      = '0;
      presenting = 0;
      hold_pend  = 0;
   endtask

   initial begin
      int n;
      rst_n         = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = '0;
      m_axis_tready = 1'b0;
      vld_always    = 1;
      rdy_mode      = 1;
      chk_stall     = 0;
      cyc           = 0;
      model_reset();
      clr_trk();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_tready", cv_t'(s_axis_tready), cv_t'(0));
      chk("rst_out", out_now(), cv_t'(0));
      chk_cnt("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 64-byte single-beat good frame, latency 1
      build_frame(1, '1, 0, 0);
      model_frame();
      clr_trk();
      drain(100);
      chk("t1_latency", cv_t'(first_out_cyc - first_acc_cyc), cv_t'(1));
      chk("t1_frames", cv_t'(stat_frames), cv_t'(1));
      chk_cnt("t1");

      // 60-byte runt with upper 4 bytes masked
      build_frame(1, 64'h0FFF_FFFF_FFFF_FFFF, 1, 0);
      model_frame();
      drain(100);
      chk("t2_runt", cv_t'(stat_runt), cv_t'(1));
      chk_cnt("t2");

      // 1600-byte frame truncated after 24 beats, error flag on dropped tail
      build_frame(25, '1, 0, 1);
      model_frame();
      clr_trk();
      drain(200);
      chk("t3_out_beats", cv_t'(out_cnt), cv_t'(24));
      chk_cnt("t3");

      // 150-byte frame under a fixed backpressure pattern
      build_frame(3, 64'h0000_0000_003F_FFFF, 0, 0);
      model_frame();
      clr_trk();
      rdy_mode  = 2;
      chk_stall = 1;
      drain(100);
      chk_stall = 0;
      rdy_mode  = 1;
      chk("t4_out_beats", cv_t'(out_cnt), cv_t'(3));
      chk_cnt("t4");

      // Reset after beat 2 of a 4-beat frame
      build_frame(4, '1, 0, 0);
      model_frame();
      clr_trk();
      n = 0;
      while (acc_cnt < 2 && n < 100) begin
         step();
         n++;
      end
      chk("t5_pre_accepts", cv_t'(acc_cnt), cv_t'(2));
      s_axis_tvalid = 1'b0;
      rst_n         = 1'b0;
      model_reset();
      @(negedge clk);
      chk("t5_rst_valid", cv_t'(m_axis_tvalid), cv_t'(0));
      chk("t5_rst_s_tready", cv_t'(s_axis_tready), cv_t'(0));
      chk_cnt("t5_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      build_frame(1, '1, 0, 0);
      model_frame();
      drain(100);
      chk_cnt("t5_post");

      // 100 back-to-back 64-byte frames at full throughput
      for (int i = 0; i < 100; i++) begin
         build_frame(1, '1, 0, 0);
         model_frame();
      end
      clr_trk();
      drain(400);
      chk("t6_out_beats", cv_t'(out_cnt), cv_t'(100));
      chk("t6_consecutive", cv_t'(last_out_cyc - first_out_cyc), cv_t'(99));
      chk_cnt("t6");

      // Randomized frames with random keep, error flags, valid and ready
      vld_always = 0;
      rdy_mode   = 0;
      for (int f = 0; f < 60; f++) begin
         build_frame($urandom_range(30, 1), '1, 0, 0);
         foreach (fr_q[i]) begin
            if ($urandom_range(3) == 0)  fr_q[i].keep = {$urandom, $urandom};
            if ($urandom_range(7) == 0)  fr_q[i].user = 1'b1;
         end
         if ($urandom_range(9) == 0) fr_q[fr_q.size()-1].keep = '0;
         model_frame();
      end
      drain(20000);
      chk_cnt("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
